// File: rtl/mem_arb.sv
// mem_arb: arbitrates instruction-fetch and load/store requests onto a single
// memory port. One command is in flight at a time. Data wins by default; a
// starvation counter eventually lets a waiting fetch through.
module mem_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic          if_flush_i,
    output logic          if_ack_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    input  logic [3:0]    dm_sel_i,
    output logic          dm_ack_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_sel_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          stallreq_if_o,
    output logic          stallreq_mem_o
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_sel_q, mem_sel_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          drop_q, drop_d;

    logic if_ok;
    logic starve_full;

    assign if_ok       = if_req_i && !if_flush_i;
    assign starve_full = (starve_cnt_q == LIMIT);

    // Next-state, command latching on grant, and same-cycle ack/rdata steering
    always_comb begin
        state_d      = state_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_sel_d    = mem_sel_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;
        if_ack_o     = 1'b0;
        if_rdata_o   = '0;
        dm_ack_o     = 1'b0;
        dm_rdata_o   = '0;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // Fetch only wins when data is absent or the fetch has starved
                if (if_ok && (!dm_req_i || starve_full)) begin
                    state_d      = BUSY_IF;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr_i;
                    mem_wdata_d  = '0;
                    mem_sel_d    = 4'hF;
                    starve_cnt_d = '0;
                end else if (dm_req_i) begin
                    state_d     = BUSY_DM;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    mem_sel_d   = dm_sel_i;
                    if (!if_req_i)
                        starve_cnt_d = '0;
                    else if (!starve_full)
                        starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            BUSY_IF: begin
                if (if_flush_i)
                    drop_d = 1'b1;
                if (mem_ack_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving in the ack cycle itself also kills the fetch
                    if (!drop_q && !if_flush_i) begin
                        if_ack_o   = 1'b1;
                        if_rdata_o = mem_rdata_i;
                    end
                end
            end
            BUSY_DM: begin
                if (mem_ack_i) begin
                    state_d    = IDLE;
                    dm_ack_o   = 1'b1;
                    dm_rdata_o = mem_we_q ? '0 : mem_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_sel_q    <= '0;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_sel_q    <= mem_sel_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_sel_o   = mem_sel_q;

    assign stallreq_if_o  = if_req_i && !if_flush_i && !if_ack_o;
    assign stallreq_mem_o = dm_req_i && !dm_ack_o;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: random fetch/load/store traffic plus short directed runs.
// Expected read data is queued when a request is issued; a monitor pops on ack.
module tb_mem_arb;
    localparam int LIMIT = 4;

    logic        clk, rst;
    logic        if_req_i, if_flush_i, if_ack_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_ack_o;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic [3:0]  dm_sel_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_sel_o;
    logic        stallreq_if_o, stallreq_mem_o;

    mem_arb #(.STARVE_LIMIT(LIMIT), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_sel_i(dm_sel_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int n_dm_ack = 0, n_if_ack = 0, last_dm_cyc = 0;
    int fix_d = -1, stray_cnt = 0;
    int dm_pct = 0, if_pct = 0, fl_pct = 0, if_st = 0;
    logic rnd_on = 1'b0;

    logic [31:0] dm_q[$];
    logic [31:0] if_q[$];
    logic [31:0] mem_img [logic [31:0]];

    // snapshot of the previous cycle taken at negedge
    logic        s_rst = 1'b1, s_idle = 1'b1, s_dm = 1'b0, s_if = 1'b0;
    logic        s_fl = 1'b0, s_mack = 1'b0, s_we = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0, s_if_addr = '0;
    logic [3:0]  s_sel = '0;
    logic        m_dm_ack = 1'b0, m_if_ack = 1'b0;
    logic        cur_is_if = 1'b0, kill = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memval(logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic dm_issue(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] sel);
        dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = a; dm_wdata_i = wd; dm_sel_i = sel;
        dm_q.push_back(we ? 32'h0 : memval(a));
    endtask

    task automatic if_issue(logic [31:0] a);
        if_req_i = 1'b1; if_addr_i = a; if_st = 1;
        if_q.push_back(memval(a));
    endtask

    // One clock of master behaviour: drop requests on ack, optional random traffic
    task automatic step();
        @(posedge clk); #1;
        if_flush_i = 1'b0;
        if (dm_req_i && m_dm_ack) dm_req_i = 1'b0;
        if (if_st == 2) begin
            if_req_i = 1'b0; if_st = 0;
        end else if (if_req_i && m_if_ack) begin
            if_req_i = 1'b0; if_st = 0;
        end
        if (rnd_on) begin
            if (!dm_req_i && $urandom_range(0, 99) < dm_pct)
                dm_issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2,
                         $urandom, 4'($urandom_range(0, 15)));
            if (!if_req_i && $urandom_range(0, 99) < if_pct)
                if_issue(32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 99) < fl_pct) begin
                if_flush_i = 1'b1;
                if (if_req_i) begin
                    if_q.delete();
                    if_st = 2;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; dm_req_i = 1'b0; if_req_i = 1'b0; if_flush_i = 1'b0; if_st = 0;
        dm_q.delete(); if_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_dm(int budget);
        int n0 = n_dm_ack;
        int k = 0;
        while (n_dm_ack == n0 && k < budget) begin step(); k++; end
        if (n_dm_ack == n0) begin
            total++; bad++;
            $display("FAIL dm_ack_timeout: got none want ack within %0d cycles", budget);
        end
    endtask

    task automatic wait_if(int budget);
        int n0 = n_if_ack;
        int k = 0;
        while (n_if_ack == n0 && k < budget) begin step(); k++; end
        if (n_if_ack == n0) begin
            total++; bad++;
            $display("FAIL if_ack_timeout: got none want ack within %0d cycles", budget);
        end
    endtask

    task automatic drain(int budget);
        int k = 0;
        rnd_on = 1'b0;
        while ((dm_req_i || if_req_i || mem_req_o) && k < budget) begin step(); k++; end
        if (dm_req_i || if_req_i || mem_req_o) begin
            total++; bad++;
            $display("FAIL drain_timeout: requests still pending after %0d cycles", budget);
        end
    endtask

    // Monitor: snapshot inputs, check acks/rdata against the scoreboard and stalls
    initial begin : monitor
        logic exp_d, exp_i;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            s_rst = rst; s_idle = !mem_req_o; s_dm = dm_req_i; s_if = if_req_i;
            s_fl = if_flush_i; s_mack = mem_ack_i; s_we = dm_we_i; s_addr = dm_addr_i;
            s_wdata = dm_wdata_i; s_sel = dm_sel_i; s_if_addr = if_addr_i;
            m_dm_ack = dm_ack_o; m_if_ack = if_ack_o;
            if (!mem_req_o) kill = 1'b0;
            else if (if_flush_i) kill = 1'b1;
            if (rst) begin
                chk("rst_acks", 64'({dm_ack_o, if_ack_o}), 64'(0));
            end else begin
                exp_d = mem_req_o && mem_ack_i && !cur_is_if;
                exp_i = mem_req_o && mem_ack_i && cur_is_if && !kill;
                chk("dm_ack", 64'(dm_ack_o), 64'(exp_d));
                chk("if_ack", 64'(if_ack_o), 64'(exp_i));
                if (dm_ack_o) begin
                    n_dm_ack++; last_dm_cyc = cyc;
                    if (dm_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL dm_ack_unexpected: got ack want none");
                    end else begin
                        e = dm_q.pop_front();
                        chk("dm_rdata", 64'(dm_rdata_o), 64'(e));
                    end
                end else chk("dm_rdata_zero", 64'(dm_rdata_o), 64'(0));
                if (if_ack_o) begin
                    n_if_ack++;
                    if (if_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL if_ack_unexpected: got ack want none");
                    end else begin
                        e = if_q.pop_front();
                        chk("if_rdata", 64'(if_rdata_o), 64'(e));
                    end
                end else chk("if_rdata_zero", 64'(if_rdata_o), 64'(0));
                chk("stall_if", 64'(stallreq_if_o), 64'(if_req_i && !if_flush_i && !exp_i));
                chk("stall_mem", 64'(stallreq_mem_o), 64'(dm_req_i && !exp_d));
            end
        end
    end

    // Memory model plus grant/command checker (reference arbitration from the rules)
    initial begin : mem_model
        int busy_n, d, streak, stray_done;
        logic gi, gd, wd_chk;
        logic [36:0] exp_cmd;
        logic [31:0] exp_wd;
        busy_n = 0; d = 0; streak = 0; stray_done = 0; wd_chk = 1'b0;
        exp_cmd = '0; exp_wd = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (s_rst) begin
                chk("rst_mem_req", 64'(mem_req_o), 64'(0));
                chk("rst_cmd", 64'({mem_we_o, mem_addr_o, mem_sel_o}), 64'(0));
                chk("rst_wdata", 64'(mem_wdata_o), 64'(0));
                streak = 0;
            end else if (s_idle) begin
                gi = s_if && !s_fl && (!s_dm || streak == LIMIT);
                gd = !gi && s_dm;
                if (gi) begin
                    cur_is_if = 1'b1; exp_cmd = {1'b0, s_if_addr, 4'hF}; wd_chk = 1'b0;
                    streak = 0;
                end else if (gd) begin
                    cur_is_if = 1'b0; exp_cmd = {s_we, s_addr, s_sel};
                    exp_wd = s_wdata; wd_chk = 1'b1;
                    if (!s_if) streak = 0;
                    else if (streak < LIMIT) streak++;
                end
                chk("grant_req", 64'(mem_req_o), 64'(gi || gd));
                if (gi || gd) begin
                    chk("grant_cmd", 64'({mem_we_o, mem_addr_o, mem_sel_o}), 64'(exp_cmd));
                    if (wd_chk) chk("grant_wdata", 64'(mem_wdata_o), 64'(exp_wd));
                end
            end else begin
                chk("busy_req", 64'(mem_req_o), 64'(!s_mack));
                if (!s_mack) begin
                    chk("hold_cmd", 64'({mem_we_o, mem_addr_o, mem_sel_o}), 64'(exp_cmd));
                    if (wd_chk) chk("hold_wdata", 64'(mem_wdata_o), 64'(exp_wd));
                end
            end
            if (mem_req_o) begin
                if (busy_n == 0) d = (fix_d >= 0) ? fix_d : int'($urandom_range(0, 4));
                mem_ack_i = (busy_n == d);
                busy_n++;
                mem_rdata_i = mem_ack_i ? memval(mem_addr_o) : $urandom;
            end else begin
                busy_n = 0;
                mem_ack_i = (stray_cnt != stray_done);
                if (mem_ack_i) stray_done++;
                mem_rdata_i = $urandom;
            end
        end
    end

    initial begin : stim
        int c0, a0, n0;
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_sel_i = '0;
        mem_img[32'h100] = 32'hDEAD_BEEF;
        step(); step();
        rst = 1'b0;
        step();

        // single load, memory answers one cycle after mem_req_o
        fix_d = 1;
        c0 = cyc;
        dm_issue(1'b0, 32'h100, 32'h0, 4'hF);
        wait_dm(20);
        chk("load_latency", 64'(last_dm_cyc - c0), 64'(2));

        // back-to-back loads with zero-wait memory: two-cycle turnaround
        fix_d = 0;
        dm_issue(1'b0, 32'h104, 32'h0, 4'hF);
        wait_dm(20);
        a0 = last_dm_cyc;
        dm_issue(1'b0, 32'h108, 32'h0, 4'hF);
        wait_dm(20);
        chk("turnaround", 64'(last_dm_cyc - a0), 64'(2));
        step();

        // collision: data first, fetch on the following idle cycle
        dm_issue(1'b0, 32'h10C, 32'h0, 4'hF);
        if_issue(32'h400);
        wait_dm(20);
        n0 = n_if_ack;
        wait_if(20);
        step();

        // store with five wait states
        fix_d = 5;
        dm_issue(1'b1, 32'h200, 32'h1234, 4'b0011);
        wait_dm(30);
        step();

        // flush while fetch in flight, ack three cycles later
        fix_d = 3;
        if_issue(32'h500);
        step();
        if_flush_i = 1'b1; if_q.delete(); if_st = 2;
        n0 = n_if_ack;
        repeat (6) step();
        chk("flush_no_ack", 64'(n_if_ack - n0), 64'(0));

        // reset mid-store, stray memory ack afterwards, then a fresh store
        fix_d = 8;
        dm_issue(1'b1, 32'h300, 32'hCAFE, 4'hF);
        repeat (3) step();
        do_reset();
        n0 = n_dm_ack;
        stray_cnt++;
        repeat (4) step();
        chk("reset_no_ack", 64'(n_dm_ack - n0), 64'(0));
        fix_d = 0;
        dm_issue(1'b1, 32'h304, 32'hBEEF, 4'b1100);
        wait_dm(20);
        step();

        // starvation: continuous data traffic with a waiting fetch
        do_reset();
        fix_d = 0; dm_pct = 100; if_pct = 100; fl_pct = 0; rnd_on = 1'b1;
        n0 = n_dm_ack;
        wait_if(80);
        chk("starve_dm_grants", 64'(n_dm_ack - n0), 64'(LIMIT));
        repeat (60) step();
        drain(100);

        // random traffic, random memory latency, occasional flushes
        fix_d = -1; dm_pct = 40; if_pct = 35; fl_pct = 4; rnd_on = 1'b1;
        repeat (3000) step();
        drain(200);
        repeat (3) step();
        chk("dm_queue_empty", 64'(dm_q.size()), 64'(0));
        chk("if_queue_empty", 64'(if_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly:
- STARVE_LIMIT, 4: max consecutive data grants while a fetch waits.
- AW, 32: address width.
- DW, 32: data width.
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req_i  in  1  fetch request, held until if_ack_o or if_flush_i.
- if_addr_i  in  AW  fetch address.
- if_flush_i  in  1  pipeline flush, kills pending or in-flight fetch.
- if_ack_o  out  1  fetch done, one-cycle pulse.
- if_rdata_o  out  DW  fetched word, valid with if_ack_o.
- dm_req_i  in  1  load/store request, held until dm_ack_o.
- dm_we_i  in  1  1 = store.
- dm_addr_i  in  AW  load/store address.
- dm_wdata_i  in  DW  store data.
- dm_sel_i  in  4  byte enables.
- dm_ack_o  out  1  load/store done, one-cycle pulse.
- dm_rdata_o  out  DW  load data, valid with dm_ack_o.
- mem_req_o  out  1  shared memory port request.
- mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o  out  1/AW/DW/4  registered command to memory.
- mem_ack_i  in  1  memory completes current command.
- mem_rdata_i  in  DW  memory read data, valid with mem_ack_i.
- stallreq_if_o  out  1  fetch stage stall request to pipeline control.
- stallreq_mem_o  out  1  memory stage stall request to pipeline control.

Function
REQ-003 FSM states SHALL be IDLE, BUSY_IF, BUSY_DM; one transaction in flight at most, no preemption.
REQ-004 IDLE arbitration SHALL be:
- dm_req_i wins, except when starve_cnt == STARVE_LIMIT and if_req_i, then IF wins.
- IF is granted only if if_req_i && !if_flush_i.
REQ-005 On grant, requester address/data/we/sel SHALL be latched into mem_*_o; the next cycle enters BUSY_x with mem_req_o=1.
- IF grant forces mem_we_o=0 and mem_sel_o=4'hF.
REQ-006 mem_*_o SHALL remain stable for the whole of BUSY_x until mem_ack_i.
REQ-007 In BUSY_x with mem_ack_i=1:
- x_ack_o=1 in the same cycle, combinational.
- x_rdata_o=mem_rdata_i; for stores, dm_rdata_o=0.
- State becomes IDLE and mem_req_o becomes 0 next cycle.
REQ-008 Ack and rdata outputs SHALL be 0 in every cycle without ack; minimum turnaround SHALL be 2 cycles per transaction with zero-wait memory.
REQ-009 if_flush_i during BUSY_IF SHALL set drop flag.
- Transaction runs to mem_ack_i; if_ack_o is suppressed.
- Drop clears on return to IDLE.
- if_flush_i has no effect on DM transactions.
REQ-010 starve_cnt (saturating at STARVE_LIMIT):
- +1 on each DM grant while if_req_i=1.
- 0 on any IF grant, or on a DM grant with if_req_i=0.
REQ-011 mem_ack_i in IDLE SHALL be ignored with no output change.
REQ-012 Stall outputs SHALL be combinational:
- stallreq_if_o = if_req_i && !if_flush_i && !if_ack_o.
- stallreq_mem_o = dm_req_i && !dm_ack_o.

Reset
REQ-013 rst=1 at a rising edge SHALL force the following, regardless of in-flight transaction:
- State IDLE; mem_req_o, mem_we_o 0; mem_addr_o, mem_wdata_o, mem_sel_o 0.
- starve_cnt 0; drop 0.
REQ-014 No ack SHALL be generated for a transaction aborted by reset; a late mem_ack_i after reset is ignored per REQ-011.

Verification
REQ-015 Single load: dm_req_i=1, addr 0x100, we=0; memory acks 1 cycle after mem_req_o with 0xDEADBEEF -> mem_addr_o=0x100 at cycle+1; dm_ack_o one pulse with dm_rdata_o=0xDEADBEEF at cycle+2; if_ack_o stays 0.
REQ-016 Collision: if_req_i and dm_req_i both rise in the same cycle -> DM granted first; IF granted on the next IDLE cycle after dm_ack_o.
REQ-017 Starvation: dm_req_i held continuously, if_req_i=1, STARVE_LIMIT=4 -> exactly 4 DM grants, then 1 IF grant, then starve_cnt=0.
REQ-018 Flush in flight: IF granted, if_flush_i pulsed in BUSY_IF, mem_ack_i 3 cycles later -> if_ack_o never asserted; state IDLE after ack; stallreq_if_o=0 while flush high.
REQ-019 Reset mid-store: rst during BUSY_DM -> mem_req_o=0 next cycle; subsequent mem_ack_i yields no dm_ack_o; fresh dm_req_i is served normally.
REQ-020 Store with wait states: dm_we_i=1, sel 4'b0011, data 0x1234; mem_ack_i delayed 5 cycles -> mem_*_o constant throughout; stallreq_mem_o=1 until the ack cycle; dm_rdata_o=0 at ack.
